// File: rtl/mmc_spi_master_if.sv
// Request/response and SPI pin bundle for mmc_spi_master.
// The master modport is the engine's view; slave is the controller/peripheral side.
interface mmc_spi_master_if;
  logic       spi_en;
  logic       spi_rd_wr;
  logic [4:0] spi_addr;
  logic [7:0] spi_data;
  logic       spi_done;
  logic [7:0] spi_rd_data;
  logic       spi_rd_valid;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    input  spi_en, spi_rd_wr, spi_addr, spi_data, spi_miso,
    output spi_done, spi_rd_data, spi_rd_valid, spi_cs_n, spi_sclk, spi_mosi
  );

  modport slave (
    output spi_en, spi_rd_wr, spi_addr, spi_data, spi_miso,
    input  spi_done, spi_rd_data, spi_rd_valid, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/mmc_spi_master.sv
// Single-register SPI mode-0 master: one 16-bit frame per request, level-ready
// spi_done back to the controller, one-cycle strobe on read completion.
module mmc_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_LEAD = 2,
  parameter int unsigned CS_LAG  = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic               sys_clk,
  input  logic               nrst,
  mmc_spi_master_if.master   bus
);
  localparam int unsigned DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int unsigned PH_MAX = (CS_LEAD > CS_LAG) ? ((CS_LEAD > CS_GAP) ? CS_LEAD : CS_GAP)
                                                      : ((CS_LAG  > CS_GAP) ? CS_LAG  : CS_GAP);
  localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  LEAD_LAST = PH_W'(CS_LEAD - 1);
  localparam logic [PH_W-1:0]  LAG_LAST  = PH_W'(CS_LAG - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_LAG   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [14:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             rd_q, rd_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_d       = rd_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    done_d     = done_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.spi_en) begin
          // Frame bit 15 goes straight to MOSI; tx holds the remaining 15 bits.
          tx_d    = {2'b00, bus.spi_addr, (bus.spi_rd_wr ? 8'h00 : bus.spi_data)};
          rd_d    = bus.spi_rd_wr;
          mosi_d  = bus.spi_rd_wr;
          cs_n_d  = 1'b0;
          done_d  = 1'b0;
          ph_d    = '0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (ph_q == LEAD_LAST) begin
          ph_d    = '0;
          div_d   = '0;
          bit_d   = 4'd15;
          state_d = S_SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], bus.spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              ph_d    = '0;
              state_d = S_LAG;
            end else begin
              bit_d  = bit_q - 4'd1;
              mosi_d = tx_q[14];
              tx_d   = {tx_q[13:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LAG: begin
        if (ph_q == LAG_LAST) begin
          ph_d    = '0;
          cs_n_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_GAP: begin
        if (ph_q == GAP_LAST) begin
          ph_d    = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (rd_q) begin
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_q       <= rd_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.spi_done     = done_q;
  assign bus.spi_rd_data  = rd_data_q;
  assign bus.spi_rd_valid = rd_valid_q;
  assign bus.spi_cs_n     = cs_n_q;
  assign bus.spi_sclk     = sclk_q;
  assign bus.spi_mosi     = mosi_q;
endmodule

// File: tb/tb_mmc_spi_master.sv
// Scoreboard bench for mmc_spi_master: default instance u0 and a fast
// instance u1 (all timing parameters 1), each with a small SPI slave model.
module tb_mmc_spi_master;
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mmc_spi_master_if b0 ();
  mmc_spi_master_if b1 ();

  logic       nrst_r [2];
  logic       en_r   [2];
  logic       rw_r   [2];
  logic [4:0] addr_r [2];
  logic [7:0] data_r [2];
  logic       miso_r [2] = '{1'b0, 1'b0};

  logic       done_s [2], cs_s [2], sclk_s [2], mosi_s [2], valid_s [2];
  logic [7:0] rdd_s  [2];

  mmc_spi_master u0 (.sys_clk(sys_clk), .nrst(nrst_r[0]), .bus(b0));
  mmc_spi_master #(.CLK_DIV(1), .CS_LEAD(1), .CS_LAG(1), .CS_GAP(1))
    u1 (.sys_clk(sys_clk), .nrst(nrst_r[1]), .bus(b1));

  assign b0.spi_en = en_r[0];   assign b1.spi_en = en_r[1];
  assign b0.spi_rd_wr = rw_r[0]; assign b1.spi_rd_wr = rw_r[1];
  assign b0.spi_addr = addr_r[0]; assign b1.spi_addr = addr_r[1];
  assign b0.spi_data = data_r[0]; assign b1.spi_data = data_r[1];
  assign b0.spi_miso = miso_r[0]; assign b1.spi_miso = miso_r[1];
  assign done_s[0] = b0.spi_done;      assign done_s[1] = b1.spi_done;
  assign cs_s[0] = b0.spi_cs_n;        assign cs_s[1] = b1.spi_cs_n;
  assign sclk_s[0] = b0.spi_sclk;      assign sclk_s[1] = b1.spi_sclk;
  assign mosi_s[0] = b0.spi_mosi;      assign mosi_s[1] = b1.spi_mosi;
  assign valid_s[0] = b0.spi_rd_valid; assign valid_s[1] = b1.spi_rd_valid;
  assign rdd_s[0] = b0.spi_rd_data;    assign rdd_s[1] = b1.spi_rd_data;

  // Hand-derived timing per instance: first SCLK rise, CS_N rise, spi_done rise, SCLK period.
  int t_rise [2] = '{6, 2};
  int t_cs   [2] = '{132, 34};
  int t_done [2] = '{136, 35};
  int t_per  [2] = '{8, 2};

  typedef struct {
    int          inst;
    logic [15:0] frame;
    bit          rd;
    logic [7:0]  rd_exp;
    int          gap;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rd [2] = '{8'h00, 8'h00};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Slave register contents returned in the data byte of read frames.
  function automatic logic [7:0] rom(input logic [4:0] a);
    case (a)
      5'h03:   rom = 8'h3C;
      5'h1F:   rom = 8'h5A;
      default: rom = {3'b101, a};
    endcase
  endfunction

  // Slave model and monitor state
  logic [15:0] cap  [2] = '{16'h0, 16'h0};
  int          nr   [2] = '{0, 0};
  logic [4:0]  sadr [2] = '{5'h0, 5'h0};
  logic [7:0]  rb;
  logic done_p [2] = '{1'b1, 1'b1};
  logic cs_p   [2] = '{1'b1, 1'b1};
  logic sclk_p [2] = '{1'b0, 1'b0};
  bit   in_fr  [2] = '{0, 0};
  int   s0 [2], first_r [2], last_r [2], cs_off [2], nrises [2], per_bad [2], gap_at [2];
  int   hi_run [2] = '{0, 0};
  int   cyc = 0;

  task automatic frame_end(input int k);
    exp_t e;
    if (!in_fr[k] || q.size() == 0) begin
      chk("unexpected_frame", 32'(k), 32'hFFFF);
      return;
    end
    e = q.pop_front();
    chk("frame_inst",   32'(k), 32'(e.inst));
    chk("mosi_frame",   {16'h0, cap[k]}, {16'h0, e.frame});
    chk("sclk_rises",   32'(nrises[k]), 32'd16);
    chk("first_rise",   32'(first_r[k]), 32'(t_rise[k]));
    chk("sclk_period",  32'(per_bad[k]), 32'd0);
    chk("cs_rise",      32'(cs_off[k]), 32'(t_cs[k]));
    chk("done_low",     32'(cyc - s0[k]), 32'(t_done[k]));
    chk("rd_valid",     {31'h0, valid_s[k]}, {31'h0, e.rd});
    chk("rd_data",      {24'h0, rdd_s[k]}, {24'h0, e.rd_exp});
    if (e.gap != 0) chk("idle_gap", 32'(gap_at[k]), 32'(e.gap));
    in_fr[k] = 0;
  endtask

  always @(posedge sys_clk) begin
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (cs_p[k] && !cs_s[k]) begin
        cap[k] = '0; nr[k] = 0; miso_r[k] = 1'b1;
      end
      if (!sclk_p[k] && sclk_s[k]) begin
        cap[k] = {cap[k][14:0], mosi_s[k]};
        nr[k]++;
        if (nr[k] == 8) sadr[k] = cap[k][4:0];
      end
      if (sclk_p[k] && !sclk_s[k] && nr[k] >= 8 && nr[k] < 16) begin
        rb = rom(sadr[k]);
        miso_r[k] = rb[15 - nr[k]];
      end
      if (!nrst_r[k]) begin
        in_fr[k] = 0;
      end else begin
        if (done_p[k] && !done_s[k]) begin
          in_fr[k] = 1; s0[k] = cyc; gap_at[k] = hi_run[k]; hi_run[k] = 0;
          first_r[k] = 0; last_r[k] = 0; cs_off[k] = 0; nrises[k] = 0; per_bad[k] = 0;
        end
        if (in_fr[k]) begin
          if (!sclk_p[k] && sclk_s[k]) begin
            nrises[k]++;
            if (nrises[k] == 1) first_r[k] = cyc - s0[k];
            else if (cyc - last_r[k] != t_per[k]) per_bad[k]++;
            last_r[k] = cyc;
          end
          if (!cs_p[k] && cs_s[k]) cs_off[k] = cyc - s0[k];
        end
        if (!done_p[k] && done_s[k]) frame_end(k);
        else if (valid_s[k]) chk("stray_valid", 32'd1, 32'd0);
        if (done_s[k]) hi_run[k]++;
      end
      done_p[k] = done_s[k]; cs_p[k] = cs_s[k]; sclk_p[k] = sclk_s[k];
    end
  end

  task automatic issue(input int k, input bit rw, input logic [4:0] a, input logic [7:0] d,
                       input bit keep, input int gap, input bit push,
                       input logic [15:0] ef, input logic [7:0] rdv);
    exp_t e;
    int n = 0;
    @(posedge sys_clk); #2;
    while (!done_s[k] && n < 400) begin
      @(posedge sys_clk); #2;
      n++;
    end
    if (!done_s[k]) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    en_r[k] = 1'b1; rw_r[k] = rw; addr_r[k] = a; data_r[k] = d;
    if (push) begin
      e.inst = k; e.frame = ef; e.rd = rw; e.gap = gap;
      e.rd_exp = rw ? rdv : last_rd[k];
      if (rw) last_rd[k] = rdv;
      q.push_back(e);
    end
    @(posedge sys_clk); #2;
    chk("accept_done_low", {31'h0, done_s[k]}, 32'd0);
    rw_r[k] = ~rw; addr_r[k] = ~a; data_r[k] = ~d;
    if (!keep) en_r[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge sys_clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (3) @(posedge sys_clk);
  endtask

  task automatic chk_reset_vals(input int k, input string tag);
    chk({tag, "_done"},  {31'h0, done_s[k]}, 32'd1);
    chk({tag, "_cs_n"},  {31'h0, cs_s[k]}, 32'd1);
    chk({tag, "_sclk"},  {31'h0, sclk_s[k]}, 32'd0);
    chk({tag, "_mosi"},  {31'h0, mosi_s[k]}, 32'd0);
    chk({tag, "_valid"}, {31'h0, valid_s[k]}, 32'd0);
    chk({tag, "_rdata"}, {24'h0, rdd_s[k]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    for (int k = 0; k < 2; k++) begin
      nrst_r[k] = 1'b1; en_r[k] = 1'b0; rw_r[k] = 1'b0; addr_r[k] = '0; data_r[k] = '0;
    end
    #1;
    nrst_r[0] = 1'b0; nrst_r[1] = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    chk_reset_vals(0, "rst0");
    chk_reset_vals(1, "rst1");
    @(negedge sys_clk);
    nrst_r[0] = 1'b1; nrst_r[1] = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge sys_clk); #2;
      for (int k = 0; k < 2; k++)
        if (sclk_s[k] !== 1'b0 || cs_s[k] !== 1'b1 || done_s[k] !== 1'b1) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Write, then read on the default instance
    issue(0, 1'b0, 5'h15, 8'hA5, 1'b0, 0, 1'b1, 16'h15A5, 8'h00);
    drain();
    issue(0, 1'b1, 5'h03, 8'h77, 1'b0, 0, 1'b1, 16'h8300, 8'h3C);
    drain();

    // Back-to-back with spi_en held high and fields scrambled while busy
    issue(0, 1'b0, 5'h0A, 8'h5C, 1'b1, 0, 1'b1, 16'h0A5C, 8'h00);
    issue(0, 1'b1, 5'h1F, 8'hFF, 1'b1, 1, 1'b1, 16'h9F00, 8'h5A);
    issue(0, 1'b0, 5'h11, 8'hFF, 1'b0, 1, 1'b1, 16'h11FF, 8'h00);
    drain();

    // Abort a read at the 7th SCLK rise
    issue(0, 1'b1, 5'h03, 8'h00, 1'b0, 0, 1'b0, 16'h0000, 8'h00);
    n = 0;
    while (nr[0] < 7 && n < 500) begin
      @(posedge sys_clk); #2;
      n++;
    end
    chk("abort_reached_rise7", 32'(nr[0]), 32'd7);
    chk("abort_sclk_high", {31'h0, sclk_s[0]}, 32'd1);
    nrst_r[0] = 1'b0;
    #1;
    chk_reset_vals(0, "abort");
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    nrst_r[0] = 1'b1;
    last_rd[0] = 8'h00;
    issue(0, 1'b0, 5'h00, 8'h01, 1'b0, 0, 1'b1, 16'h0001, 8'h00);
    drain();

    // Fast instance: minimum timing parameters
    issue(1, 1'b0, 5'h1F, 8'hFF, 1'b0, 0, 1'b1, 16'h1FFF, 8'h00);
    drain();
    issue(1, 1'b0, 5'h00, 8'h00, 1'b0, 0, 1'b1, 16'h0000, 8'h00);
    drain();
    issue(1, 1'b1, 5'h03, 8'hAA, 1'b0, 0, 1'b1, 16'h8300, 8'h3C);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmc_spi_master.md
Name: mmc_spi_master

Overview:
- Serial engine at the far end of the main controller's SPI request interface.
- Accepts single-register write/read requests (`spi_en`, `spi_rd_wr`, `spi_addr`, `spi_data`) and serializes each as one 16-bit SPI mode-0 frame to the RX front-end configuration port.
- Drives `spi_done` as a level "ready" back to the controller.
- Returns read data with a one-cycle valid strobe.

Parameters:
- CLK_DIV, 4, `sys_clk` cycles per SCLK half-period (>=1)
- CS_LEAD, 2, `sys_clk` cycles from CS_N fall to first SCLK activity (>=1)
- CS_LAG, 2, `sys_clk` cycles from last SCLK fall to CS_N rise (>=1)
- CS_GAP, 4, `sys_clk` cycles CS_N held high before `spi_done` re-asserts (>=1)

Ports:
- `sys_clk`  in  1  system clock
- `nrst`  in  1  reset, asynchronous, active-low
- `spi_en`  in  1  request; sampled only while idle
- `spi_rd_wr`  in  1  0 = write, 1 = read; captured with request
- `spi_addr`  in  5  register address; captured with request
- `spi_data`  in  8  write data; captured with request (ignored for reads)
- `spi_done`  out  1  1 = idle/ready; 0 = frame in progress
- `spi_rd_data`  out  8  last read result
- `spi_rd_valid`  out  1  one-cycle strobe, `spi_rd_data` updated
- `spi_cs_n`  out  1  chip select, active-low
- `spi_sclk`  out  1  serial clock, idles low
- `spi_mosi`  out  1  serial data out
- `spi_miso`  in  1  serial data in

Behaviour:
- One clock (`sys_clk`). Reset asynchronous active-low (`nrst`).
- Reset values: `spi_done`=1, `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `spi_rd_data`=0, `spi_rd_valid`=0, FSM=IDLE, all counters 0. Reset mid-frame aborts immediately to these values; no partial read strobe.
- Frame format, MSB first:
  - bit15 = `spi_rd_wr`
  - bits14:13 = 00
  - bits12:8 = `spi_addr`
  - bits7:0 = `spi_data` (write) or 0x00 (read)
- SPI mode 0:
  - MOSI changes only while SCLK is low.
  - MISO is sampled on the `sys_clk` edge that drives SCLK high.
- FSM states and transitions:
  - IDLE: `spi_done`=1.
    - If `spi_en`=1 on an edge: load the 16-bit shift register, capture rd_wr, set `spi_cs_n`=0, `spi_done`=0, `spi_mosi`=frame[15], go to LEAD.
    - The acceptance edge is E0.
  - LEAD: hold CS_LEAD cycles with SCLK low, then go to SHIFT.
  - SHIFT: 16 bits. Each bit is CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high.
    - On the rising transition, sample `spi_miso` into the receive shift register.
    - On the falling transition of bits 15..1, present the next MOSI bit.
    - After bit 0's high half, SCLK goes low; go to LAG.
  - LAG: CS_LAG cycles, then `spi_cs_n`=1; go to GAP.
  - GAP: CS_GAP cycles, then IDLE with `spi_done`=1.
    - For reads, on that same edge, `spi_rd_data` = last 8 bits sampled and `spi_rd_valid`=1 for exactly one cycle.
    - Writes leave `spi_rd_data` unchanged and never strobe.
- Timing with default parameters:
  - First SCLK rise at E0+6.
  - `spi_cs_n` rises at E0+132.
  - `spi_done` rises at E0+136; it is low for exactly CS_LEAD+32*CLK_DIV+CS_LAG+CS_GAP cycles.
- Request handshake:
  - `spi_en` and input fields are ignored outside IDLE.
  - Inputs are captured only at E0, so later changes do not affect the frame.
  - `spi_en` held high continuously produces back-to-back frames. The next E0 is the first edge where `spi_done`=1, so `spi_done` stays high exactly one cycle between frames.
- `spi_done` is registered and glitch-free, because the controller uses its rising edge as a clock.
- Counters:
  - Divider counter width is ceil(log2(CLK_DIV))+1.
  - Bit counter is 4 bits, counts 15 down to 0, no wrap beyond 0.
  - Phase counter is sized for max(CS_LEAD, CS_LAG, CS_GAP).

Test Plan:
- Reset idle: hold `nrst`=0 -> `spi_done`=1, `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `spi_rd_valid`=0; no SCLK toggles for 50 cycles with `spi_en`=0.
- Write frame: `spi_en` pulse with rd_wr=0, addr=0x15, data=0xA5 -> slave model captures 0x15A5 (16 bits); first SCLK rise at E0+6; `spi_cs_n` low E0..E0+131; `spi_done` low 136 cycles; no `spi_rd_valid`.
- Read frame: rd_wr=1, addr=0x03; model returns 0x3C in the data byte -> MOSI frame 0x8300; `spi_rd_data`=0x3C with a one-cycle `spi_rd_valid` on the same edge `spi_done` rises.
- Back-to-back: `spi_en` tied high, three different requests queued in the stimulus -> three frames in order; `spi_done` high exactly 1 cycle between frames; fields changed during busy are not reflected on MOSI.
- Abort: deassert `nrst` at SCLK rise 7 of a read -> outputs return to reset values asynchronously; no strobe. After release, a new write 0x0001 completes correctly.
- Parameter sweep: CLK_DIV=1, CS_LEAD=CS_LAG=CS_GAP=1 -> `spi_done` low 35 cycles; SCLK period 2 cycles; data integrity for 0x1FFF and 0x0000 frames.
